multiword_addsub_sequencer: RTL and testbench
=============================================

Name: multiword_addsub_sequencer

Overview:
- Sequences a single shared `carry_lookahead_adder_16b` instance to perform WIDTH-bit unsigned/two's-complement add and subtract, one 16-bit limb per clock, least significant limb first.
- Carry between limbs is held in a register.
- Sits between the accelerator command front-end (valid/ready) and result consumers (valid/ready).
- Replaces a wide combinational adder with a small iterative one.

Parameters:
- WORDS, 4, number of 16-bit limbs; WIDTH = 16*WORDS; legal range 2..16.

Ports:
- iClk  input  1  clock, rising edge
- iRstN  input  1  asynchronous active-low reset
- iValid  input  1  operation request valid
- oReady  output  1  block can accept a request
- iSub  input  1  0 = A+B, 1 = A-B
- iA  input  WIDTH  operand A
- iB  input  WIDTH  operand B
- oValid  output  1  result valid
- iReady  input  1  consumer accepts result
- oResult  output  WIDTH  sum/difference
- oCarry  output  1  final carry out; for subtract, 1 = no borrow (A >= B unsigned)

Behaviour:
- Reset is asynchronous and active-low; one clock.
- Reset values:
  - state = IDLE
  - oValid = 0, oResult = 0, oCarry = 0
  - limb counter = 0, carry register = 0
  - oReady = 1, since it is decoded from IDLE.
- States:
  - IDLE:
    - oReady = 1.
    - On iValid & oReady, register A, (iSub ? ~B : B), carry = iSub, counter = 0; go to RUN.
    - iValid = 0 leaves the block in IDLE.
  - RUN:
    - oReady = 0.
    - Each cycle, the adder takes limb[counter] of the registered A and B' plus the carry register.
    - The 16-bit sum is written to oResult[16*counter +: 16].
    - The carry register takes the adder carry-out and the counter increments.
    - When counter == WORDS-1: latch final carry into oCarry, set oValid = 1, go to DONE.
  - DONE:
    - oValid = 1, oReady = 0; oResult and oCarry held stable.
    - On iReady: oValid = 0 next cycle, go to IDLE.
    - iReady = 0 holds indefinitely.
- Latency: request accepted on edge N; oValid high after edge N+WORDS; minimum issue interval WORDS+2 cycles.
- iValid, iA, iB and iSub are ignored outside IDLE; operands need not be held after acceptance.
- oResult contents during RUN are partial and undefined to consumers; only sampled when oValid = 1.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Subtraction uses ~B + 1, injected as initial carry.
- iRstN low in any state, including mid-RUN: immediate return to reset values; the in-flight operation is discarded and no oValid is produced.
- oValid is a registered output; no combinational path from iValid or iReady to any output.

Optional Feature:
- Macro: ADDSUB_FLAGS_EN.
- When defined, adds two outputs, both registered, valid with oValid, reset 0, held in DONE:
  - oZero (1 bit): oResult == 0.
  - oOverflow (1 bit): signed overflow, computed as (A[MSB] == B'[MSB]) & (result[MSB] != A[MSB]) using the registered operands.
- When undefined, the ports and their logic are absent; all other behaviour is identical.

Test Plan (WORDS=4):
1. Add 0x0000_0000_0000_FFFF + 0x1 -> oResult 0x0000_0000_0001_0000, oCarry 0; oValid rises exactly 4 cycles after the accept edge; oReady low until oValid is consumed.
2. Add 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> oResult 0, oCarry 1 (oZero 1 with ADDSUB_FLAGS_EN).
3. Subtract 0x5 - 0x7 -> oResult 0xFFFF_FFFF_FFFF_FFFE, oCarry 0; subtract 0x7 - 0x5 -> 0x2, oCarry 1.
4. Backpressure:
   - Hold iReady = 0 for 10 cycles after oValid: oResult and oCarry stable and oReady 0.
   - A second iValid with different operands in that window is ignored.
   - After iReady, oValid drops next cycle and the new request is accepted only from IDLE.
5. Reset mid-operation: assert iRstN = 0 after 2 RUN cycles -> oValid 0, oResult 0, oCarry 0, oReady 1 immediately. After release, add 0x3 + 0x4 -> 0x7 with no stale data.
6. ADDSUB_FLAGS_EN:
   - 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> oOverflow 1, oCarry 0.
   - 0x8000_0000_0000_0000 - 0x1 -> oOverflow 1.
   - 0x1 + 0x1 -> oOverflow 0, oZero 0.

Source files
------------

// File: rtl/multiword_addsub_sequencer.sv
// Iterative WIDTH-bit add/subtract built on one shared 16-bit carry-lookahead adder.
// Define ADDSUB_FLAGS_EN to add the registered oZero/oOverflow result flags.

module carry_lookahead_adder_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic [15:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
  end

  // Second lookahead level: group carries straight from cin, no ripple between groups.
  always_comb begin
    gc    = '0;
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
  end

  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];
endmodule

// state | meaning
// IDLE  | ready for a request; operands captured on iValid
// RUN   | one limb per cycle through the shared adder, LS limb first
// DONE  | result and carry held with oValid until iReady
module multiword_addsub_sequencer #(
  parameter  int WORDS = 4,
  localparam int WIDTH = 16 * WORDS
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iValid,
  output logic             oReady,
  input  logic             iSub,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oResult,
  output logic             oCarry
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic             oZero,
  output logic             oOverflow
`endif
);
  localparam int CW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CW-1:0]           cnt;
  logic [WORDS-1:0][15:0]  a_reg;
  logic [WORDS-1:0][15:0]  b_reg;
  logic [WORDS-1:0][15:0]  res_reg;
  logic                    carry_reg;
  logic                    carry_out_reg;
  logic                    valid_reg;
  logic [15:0]             limb_sum;
  logic                    limb_cout;
  logic                    last;

  assign last = (cnt == CW'(WORDS - 1));

  carry_lookahead_adder_16b u_cla (
    .a    (a_reg[cnt]),
    .b    (b_reg[cnt]),
    .cin  (carry_reg),
    .sum  (limb_sum),
    .cout (limb_cout)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iValid) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    if (iReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction stores ~B and seeds the carry with 1, giving A + ~B + 1.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cnt           <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      res_reg       <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      valid_reg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iValid) begin
            a_reg     <= iA;
            b_reg     <= iSub ? ~iB : iB;
            carry_reg <= iSub;
            cnt       <= '0;
          end
        end
        RUN: begin
          res_reg[cnt] <= limb_sum;
          carry_reg    <= limb_cout;
          cnt          <= cnt + CW'(1);
          if (last) begin
            carry_out_reg <= limb_cout;
            valid_reg     <= 1'b1;
          end
        end
        DONE: begin
          if (iReady) valid_reg <= 1'b0;
        end
        default: valid_reg <= 1'b0;
      endcase
    end
  end

`ifdef ADDSUB_FLAGS_EN
  logic [WORDS-1:0][15:0] res_full;
  logic                   zero_reg;
  logic                   ovf_reg;

  // Full result as it will be after the current limb lands; only used on the last limb.
  always_comb begin
    res_full      = res_reg;
    res_full[cnt] = limb_sum;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      zero_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (state == RUN && last) begin
      zero_reg <= (res_full == '0);
      ovf_reg  <= (a_reg[WORDS-1][15] == b_reg[WORDS-1][15]) &
                  (limb_sum[15] != a_reg[WORDS-1][15]);
    end
  end

  assign oZero     = zero_reg;
  assign oOverflow = ovf_reg;
`endif

  assign oReady  = (state == IDLE);
  assign oValid  = valid_reg;
  assign oResult = res_reg;
  assign oCarry  = carry_out_reg;
endmodule

// File: tb/tb_multiword_addsub_sequencer.sv
// Self-checking bench for multiword_addsub_sequencer (WORDS=4): vector table, scoreboard queue,
// plus backpressure and mid-operation reset sequences.
module tb_multiword_addsub_sequencer;
  localparam int WORDS = 4;

  logic        iClk   = 1'b0;
  logic        iRstN  = 1'b0;
  logic        iValid = 1'b0;
  logic        iSub   = 1'b0;
  logic        iReady = 1'b0;
  logic [63:0] iA     = '0;
  logic [63:0] iB     = '0;
  logic        oReady;
  logic        oValid;
  logic        oCarry;
  logic [63:0] oResult;
`ifdef ADDSUB_FLAGS_EN
  logic        oZero;
  logic        oOverflow;
`endif

  multiword_addsub_sequencer #(.WORDS(WORDS)) dut (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .iValid  (iValid),
    .oReady  (oReady),
    .iSub    (iSub),
    .iA      (iA),
    .iB      (iB),
    .oValid  (oValid),
    .iReady  (iReady),
    .oResult (oResult),
    .oCarry  (oCarry)
`ifdef ADDSUB_FLAGS_EN
    ,
    .oZero     (oZero),
    .oOverflow (oOverflow)
`endif
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [63:0] result;
    logic        carry;
    logic        zero;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] result;
    logic        carry;
    logic        zero;
    logic        ovf;
  } vec_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic sub, input logic [63:0] a, input logic [63:0] b);
    exp_t        e;
    logic [63:0] bp;
    logic [64:0] s;
    bp       = sub ? ~b : b;
    s        = {1'b0, a} + {1'b0, bp} + {64'd0, sub};
    e.result = s[63:0];
    e.carry  = s[64];
    e.zero   = (s[63:0] == 64'd0);
    e.ovf    = (a[63] == bp[63]) && (s[63] != a[63]);
    return e;
  endfunction

  task automatic start_op(input logic sub, input logic [63:0] a, input logic [63:0] b,
                          input exp_t e);
    @(negedge iClk);
    check("ready_idle", {63'd0, oReady}, 64'd1);
    iValid = 1'b1;
    iSub   = sub;
    iA     = a;
    iB     = b;
    @(posedge iClk);
    sb.push_back(e);
    #1;
    iValid = 1'b0;
    iA     = ~a;
    iB     = ~b;
    iSub   = ~sub;
  endtask

  task automatic wait_valid();
    int cyc = 0;
    while (oValid !== 1'b1 && cyc < 20) begin
      check("ready_busy", {63'd0, oReady}, 64'd0);
      @(posedge iClk);
      #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(WORDS));
  endtask

  task automatic collect();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard: actual result with no pending entry, required a pending entry");
    end else begin
      e = sb.pop_front();
      check("result", oResult, e.result);
      check("carry", {63'd0, oCarry}, {63'd0, e.carry});
`ifdef ADDSUB_FLAGS_EN
      check("zero", {63'd0, oZero}, {63'd0, e.zero});
      check("overflow", {63'd0, oOverflow}, {63'd0, e.ovf});
`endif
    end
  endtask

  task automatic release_res();
    @(negedge iClk);
    iReady = 1'b1;
    @(posedge iClk);
    #1;
    iReady = 1'b0;
    check("valid_drop", {63'd0, oValid}, 64'd0);
    check("ready_back", {63'd0, oReady}, 64'd1);
  endtask

  task automatic run_op(input logic sub, input logic [63:0] a, input logic [63:0] b,
                        input exp_t e);
    start_op(sub, a, b, e);
    wait_valid();
    collect();
    release_res();
  endtask

  initial begin
    exp_t e;
    exp_t e2;

    vecs[0] = '{1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 64'h7, 64'h5, 64'h2, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 64'h1, 64'h1, 64'h2, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 64'h1234, 64'h1234, 64'h0, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0001_0000,
                64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge iClk);
    #1;
    check("rst_valid", {63'd0, oValid}, 64'd0);
    check("rst_result", oResult, 64'd0);
    check("rst_carry", {63'd0, oCarry}, 64'd0);
    check("rst_ready", {63'd0, oReady}, 64'd1);
`ifdef ADDSUB_FLAGS_EN
    check("rst_zero", {63'd0, oZero}, 64'd0);
    check("rst_overflow", {63'd0, oOverflow}, 64'd0);
`endif
    @(negedge iClk);
    iRstN = 1'b1;

    for (int i = 0; i < 9; i++) begin
      e = '{vecs[i].result, vecs[i].carry, vecs[i].zero, vecs[i].ovf};
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, e);
    end

    for (int i = 0; i < 6; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rs;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      run_op(rs, ra, rb, model(rs, ra, rb));
    end

    // Backpressure: hold the result 10 cycles while a competing request is presented.
    e  = '{64'h3333_3333_3333_3333, 1'b0, 1'b0, 1'b0};
    e2 = '{64'h9998_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    start_op(1'b0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, e);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      iValid = 1'b1;
      iSub   = 1'b1;
      iA     = 64'h9999_0000_0000_0003;
      iB     = 64'h4;
      @(posedge iClk);
      #1;
      check("hold_result", oResult, 64'h3333_3333_3333_3333);
      check("hold_carry", {63'd0, oCarry}, 64'd0);
      check("hold_ready", {63'd0, oReady}, 64'd0);
      check("hold_valid", {63'd0, oValid}, 64'd1);
    end
    collect();
    @(negedge iClk);
    iReady = 1'b1;
    @(posedge iClk);
    #1;
    iReady = 1'b0;
    check("bp_valid_drop", {63'd0, oValid}, 64'd0);
    check("bp_ready_idle", {63'd0, oReady}, 64'd1);
    @(posedge iClk);
    sb.push_back(e2);
    #1;
    iValid = 1'b0;
    check("bp_accept_from_idle", {63'd0, oReady}, 64'd0);
    wait_valid();
    collect();
    release_res();

    // Reset after two RUN cycles discards the operation.
    start_op(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111,
             model(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111));
    @(posedge iClk);
    #1;
    @(posedge iClk);
    #2;
    iRstN = 1'b0;
    #1;
    check("midrst_valid", {63'd0, oValid}, 64'd0);
    check("midrst_result", oResult, 64'd0);
    check("midrst_carry", {63'd0, oCarry}, 64'd0);
    check("midrst_ready", {63'd0, oReady}, 64'd1);
    sb.delete();
    @(negedge iClk);
    @(negedge iClk);
    iRstN = 1'b1;
    repeat (6) @(posedge iClk);
    #1;
    check("midrst_no_valid", {63'd0, oValid}, 64'd0);
    run_op(1'b0, 64'h3, 64'h4, '{64'h7, 1'b0, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
